// File: rtl/conv_mac_if.sv
// Valid/ready bus between the window generator, the conv MAC engine and the feature-map writer.
// The master drives beats in and accepts results; the slave is the engine.
`timescale 1ns/1ps
interface conv_mac_if #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 25,
    parameter int K      = 4
) ();
    logic                      in_valid;
    logic                      in_ready;
    logic [K*K*DATA_W-1:0]     data_in;
    logic [K*K*DATA_W-1:0]     kernel_in;
    logic signed [ACC_W-1:0]   bias_in;
    logic                      out_valid;
    logic                      out_ready;
    logic signed [ACC_W-1:0]   out_result;
    logic                      out_sat;

    modport master (
        output in_valid, data_in, kernel_in, bias_in, out_ready,
        input  in_ready, out_valid, out_result, out_sat
    );

    modport slave (
        input  in_valid, data_in, kernel_in, bias_in, out_ready,
        output in_ready, out_valid, out_result, out_sat
    );
endinterface

// File: rtl/conv_mac_pipe.sv
// Pipelined KxK convolution MAC: products, adder tree, then per-group accumulate with
// bias, optional saturation and ReLU into a registered valid/ready output.
`timescale 1ns/1ps
module conv_mac_pipe #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 25,
    parameter int K      = 4,
    parameter int NUM_CH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        relu_en,
    input  logic        sat_en,
    conv_mac_if.slave   bus
);
    localparam int NP = K * K;
    localparam int PW = 2 * DATA_W;
    localparam int AW = ACC_W + $clog2(NUM_CH) + 1;
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CW-1:0] LAST_CH = CW'(NUM_CH - 1);
    localparam logic signed [AW-1:0] SAT_MAX = {{(AW-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(AW-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

    logic                    w_advance;
    logic                    w_accept;
    logic                    w_first;
    logic                    w_last;
    logic [CW-1:0]           r_chCnt;

    logic                    r_s1Valid;
    logic                    r_s1First;
    logic                    r_s1Last;
    logic signed [PW-1:0]    r_s1Prod [NP];
    logic signed [ACC_W-1:0] r_s1Bias;

    logic signed [AW-1:0]    w_winSum;
    logic                    r_s2Valid;
    logic                    r_s2First;
    logic                    r_s2Last;
    logic signed [AW-1:0]    r_s2Sum;
    logic signed [ACC_W-1:0] r_s2Bias;

    logic signed [AW-1:0]    w_accNext;
    logic signed [AW-1:0]    r_acc;
    logic signed [ACC_W-1:0] w_satVal;
    logic                    w_satFlag;
    logic signed [ACC_W-1:0] w_finalVal;
    logic                    r_outValid;
    logic signed [ACC_W-1:0] r_outResult;
    logic                    r_outSat;

    // The whole pipeline moves only when the output register is free or being drained.
    assign w_advance = !(r_outValid && !bus.out_ready);
    assign bus.in_ready = w_advance && !clear;
    assign w_accept = bus.in_valid && bus.in_ready;
    assign w_first = (r_chCnt == '0);
    assign w_last = (r_chCnt == LAST_CH);

    assign bus.out_valid = r_outValid;
    assign bus.out_result = r_outResult;
    assign bus.out_sat = r_outSat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_chCnt <= '0;
            r_s1Valid <= 1'b0;
            r_s1First <= 1'b0;
            r_s1Last <= 1'b0;
            r_s1Bias <= '0;
            for (int i = 0; i < NP; i++) begin
                r_s1Prod[i] <= '0;
            end
        end else if (clear) begin
            r_chCnt <= '0;
            r_s1Valid <= 1'b0;
        end else if (w_advance) begin
            r_s1Valid <= w_accept;
            if (w_accept) begin
                r_s1First <= w_first;
                r_s1Last <= w_last;
                r_s1Bias <= bus.bias_in;
                r_chCnt <= w_last ? '0 : r_chCnt + 1'b1;
                for (int i = 0; i < NP; i++) begin
                    r_s1Prod[i] <= PW'($signed(bus.data_in[i*DATA_W +: DATA_W]))
                                 * PW'($signed(bus.kernel_in[i*DATA_W +: DATA_W]));
                end
            end
        end
    end

    always_comb begin
        w_winSum = '0;
        for (int i = 0; i < NP; i++) begin
            w_winSum = w_winSum + AW'(r_s1Prod[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2Valid <= 1'b0;
            r_s2First <= 1'b0;
            r_s2Last <= 1'b0;
            r_s2Sum <= '0;
            r_s2Bias <= '0;
        end else if (clear) begin
            r_s2Valid <= 1'b0;
        end else if (w_advance) begin
            r_s2Valid <= r_s1Valid;
            if (r_s1Valid) begin
                r_s2First <= r_s1First;
                r_s2Last <= r_s1Last;
                r_s2Sum <= w_winSum;
                r_s2Bias <= r_s1Bias;
            end
        end
    end

    // Bias enters only with the first channel; later channels add onto the running sum.
    assign w_accNext = r_s2First ? (AW'(r_s2Bias) + r_s2Sum) : (r_acc + r_s2Sum);

    always_comb begin
        w_satFlag = 1'b0;
        w_satVal = w_accNext[ACC_W-1:0];
        if (sat_en) begin
            if (w_accNext > SAT_MAX) begin
                w_satVal = SAT_MAX[ACC_W-1:0];
                w_satFlag = 1'b1;
            end else if (w_accNext < SAT_MIN) begin
                w_satVal = SAT_MIN[ACC_W-1:0];
                w_satFlag = 1'b1;
            end
        end
        w_finalVal = (relu_en && w_satVal[ACC_W-1]) ? '0 : w_satVal;
    end

    // Accumulate and publish in the same edge so a finished group lands at the output directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
            r_outValid <= 1'b0;
            r_outResult <= '0;
            r_outSat <= 1'b0;
        end else if (clear) begin
            r_acc <= '0;
            r_outValid <= 1'b0;
        end else if (w_advance) begin
            if (r_s2Valid) begin
                r_acc <= w_accNext;
            end
            if (r_s2Valid && r_s2Last) begin
                r_outValid <= 1'b1;
                r_outResult <= w_finalVal;
                r_outSat <= w_satFlag;
            end else begin
                r_outValid <= 1'b0;
            end
        end
    end
endmodule
